rv32_ahb_lite_master_pipe: RTL and testbench
============================================

# rv32_ahb_lite_master_pipe

Parametrised, fully pipelined AHB-Lite master for the RV32IM core family. It arbitrates instruction-fetch and load/store requests onto one AHB-Lite port. Address and data phases are separated, so a new address phase overlaps the previous data phase. It adds valid/ready handshakes, HREADY wait states, two-cycle HRESP error handling, write-lane replication, load extraction/extension and misalignment faults.

## Interface
- ADDR_W, 32, HADDR and request address width.
- DATA_W, 32, bus data width; only 32 is supported, and elaboration errors otherwise.
- DATA_PRIO, 1: when 1, data requests win over instruction requests. When 0, arbitration is round-robin, alternating on every accepted transfer.
- clk  in  1  clock.
- rst_n  in  1  active-low reset, asynchronous assert, synchronous deassert outside the block.
- i_req_valid / i_req_ready  in/out  1  fetch request handshake.
- i_req_addr  in  ADDR_W  fetch address (word).
- i_rsp_valid  out  1  fetch response strobe.
- i_rsp_rdata  out  DATA_W  instruction word.
- i_rsp_err  out  1  bus error or misaligned fetch.
- d_req_valid / d_req_ready  in/out  1  load/store request handshake.
- d_req_addr  in  ADDR_W  byte address.
- d_req_write  in  1  1 = store.
- d_req_size  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- d_req_wdata  in  DATA_W  store data, right-aligned.
- d_rsp_valid  out  1  data response strobe.
- d_rsp_rdata  out  DATA_W  load data, extracted and extended.
- d_rsp_err  out  1  error.
- HADDR  out  ADDR_W.
- HSIZE  out  3.
- HTRANS  out  2.
- HWRITE  out  1.
- HWDATA  out  DATA_W.
- HBURST  out  3  constant 000.
- HPROT  out  4  0010 for fetch, 0011 for data.
- HRDATA  in  DATA_W.
- HREADY  in  1.
- HRESP  in  1.

## Operation
- **Address phase (combinational):** the arbiter selects one valid request and drives HADDR, HSIZE, HWRITE and HPROT, with HTRANS=NONSEQ (10).
  - With no valid request: HTRANS=IDLE (00), HWRITE=0, HADDR=0.
  - Fetches always use HSIZE=010.
- **Acceptance:** a request is accepted when its ready is high, i.e. it is selected and HREADY=1. Ready is asserted only for the selected request.
  - An unaccepted request must be held stable by the requester. The master never drops or reorders it.
- **Data-phase tracker:** state DP_IDLE, DP_BUSY or DP_ERR, plus registered owner (I/D), write flag, size, addr[1:0], fault flag and wdata.
  - It loads on every accepted request and returns to DP_IDLE when the phase completes with nothing new accepted.
- **Misalignment:** an H/HU access with addr[0]=1, a W access with addr[1:0]≠00, or a fetch with addr[1:0]≠00 is a fault.
  - A faulting request is accepted as normal, but HTRANS is driven IDLE for it.
  - Its data phase completes on the next HREADY=1 with rsp_valid=1, rsp_err=1 and rdata=0.
- **Write data:** HWDATA is driven from the registered wdata during the data phase.
  - Byte stores replicate wdata[7:0] into all 4 lanes.
  - Half stores replicate wdata[15:0] into both halves.
  - Word stores pass wdata through.
  - HWDATA is 0 when the tracker is idle.
- **Load data:** the lane is selected by the registered addr[1:0]. B and H are sign-extended; BU and HU are zero-extended; W passes through.
- **Responses:** the owner's rsp_valid is high for exactly one cycle when its data phase completes (HREADY=1) with HRESP=0, and rsp_err=0.
- **Error (AHB-Lite two-cycle):**
  - Cycle 1 has HRESP=1 and HREADY=0. The tracker enters DP_ERR and the master forces HTRANS=IDLE, which cancels the pending address phase. No request is accepted in this cycle.
  - Cycle 2 has HRESP=1 and HREADY=1. The owner gets rsp_valid=1, rsp_err=1, rdata=0, and no request is accepted.
  - The cancelled request stays pending and is re-arbitrated from the following cycle.
- **Round-robin (DATA_PRIO=0):** the priority pointer toggles after each accepted transfer and resets to "data".
- **Reset (asynchronous, rst_n=0):**
  - Tracker goes to DP_IDLE and the RR pointer to data.
  - While in reset: all ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, HTRANS=IDLE, HWDATA=0, HADDR=0.
  - A data phase in flight at reset is abandoned and no response is produced.

## Timing
- Zero-wait-state latency: request accepted in cycle N, response valid combinationally in cycle N+1. Sustained throughput is one transfer per cycle.
- Each wait state (HREADY=0) extends the data phase by one cycle and holds the address phase. The address-phase outputs stay stable while HREADY=0 (except the HTRANS=IDLE override on an error).
- rsp_* is combinational from HRDATA, HREADY and HRESP, gated by the tracker state.
- ready is combinational from valid, the arbiter and HREADY.
- Error response latency: the owner's response arrives in the second error cycle. The earliest re-issue of the cancelled request is the cycle after that.

## Test plan
- **Back-to-back, zero wait:** fetches at 0x0, 0x4, 0x8 on consecutive cycles. Expect HTRANS=10 each cycle, i_rsp_valid in cycles N+1..N+3 with the matching HRDATA, and i_req_ready=1 throughout.
- **Arbitration, DATA_PRIO=1:** simultaneous fetch 0x100 and load LW 0x200. Expect HADDR=0x200 first with HPROT=0011, then 0x100 with HPROT=0010. With DATA_PRIO=0 the two must alternate over 4 requests.
- **Lanes:** SB wdata 0xA5 at 0x203 gives HWDATA=0xA5A5A5A5 and HSIZE=000. LB at 0x203 with HRDATA=0x80xxxxxx returns 0xFFFFFF80; LBU returns 0x00000080; LHU at 0x202 with HRDATA=0x8001xxxx returns 0x00008001.
- **Wait states:** HREADY=0 for 3 cycles during a load data phase, with a fetch pending. HADDR/HTRANS must be held, d_rsp_valid must appear only on the 4th cycle, and the fetch must be accepted in that same cycle.
- **Error:** HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on a store, with a fetch pending. Expect HTRANS=IDLE in both cycles, d_rsp_err=1 in cycle 2, and the fetch re-issued in cycle 3.
- **Misaligned and reset:** LW at 0x202 gives HTRANS=IDLE and d_rsp_err=1 the next cycle with no bus transfer. Asserting rst_n=0 in a data phase drops every output to its reset value in the same cycle, and no response follows after release.

Source files
------------

// File: rtl/rv32_ahb_lite_master_pipe_if.sv
// Core request/response channels plus the AHB-Lite bus of rv32_ahb_lite_master_pipe.
// The master modport is the block's view; slave is the environment's view.
interface rv32_ahb_lite_master_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rsp_rdata;
  logic              i_rsp_err;
  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_write;
  logic [2:0]        d_req_size;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_rdata;
  logic              d_rsp_err;
  logic [ADDR_W-1:0] HADDR;
  logic [2:0]        HSIZE;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_write, d_req_size,
           d_req_wdata, HRDATA, HREADY, HRESP,
    output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err, d_req_ready, d_rsp_valid,
           d_rsp_rdata, d_rsp_err, HADDR, HSIZE, HTRANS, HWRITE, HWDATA, HBURST, HPROT
  );

  modport slave (
    output i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_write, d_req_size,
           d_req_wdata, HRDATA, HREADY, HRESP,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err, d_req_ready, d_rsp_valid,
           d_rsp_rdata, d_rsp_err, HADDR, HSIZE, HTRANS, HWRITE, HWDATA, HBURST, HPROT
  );
endinterface

// File: rtl/rv32_ahb_lite_master_pipe.sv
// Pipelined AHB-Lite master: arbitrates fetch and load/store requests onto one port,
// overlapping each address phase with the previous data phase.
module rv32_ahb_lite_master_pipe #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit DATA_PRIO = 1'b1
) (
  input logic                         clk,
  input logic                         rst_n,
  rv32_ahb_lite_master_pipe_if.master bus
);
  if (DATA_W != 32) begin : g_data_w_check
    $error("rv32_ahb_lite_master_pipe supports DATA_W = 32 only");
  end

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {DP_IDLE, DP_BUSY, DP_ERR} dp_state_e;

  dp_state_e         dp_state_p1;
  logic              rr_data_first;
  logic              dp_owner_d_p1;
  logic              dp_write_p1;
  logic              dp_fault_p1;
  logic [2:0]        dp_size_p1;
  logic [1:0]        dp_addr_p1;
  logic [DATA_W-1:0] dp_wdata_p1;

  logic              vld_p0;
  logic              sel_d_p0;
  logic              fault_p0;
  logic              err_hold;
  logic              accept_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic              vld_p1;
  logic              rsp_err_p1;
  logic [DATA_W-1:0] rsp_data_p1;

  function automatic logic data_misaligned(input logic [2:0] size, input logic [1:0] addr);
    return (size[1:0] == 2'b01 && addr[0]) || (size[1:0] == 2'b10 && addr != 2'b00);
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [2:0] size);
    case (size[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [2:0] size,
                                               input logic [1:0] addr);
    logic [31:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    lane = rdata >> {addr, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (size)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, lane[7:0]};
      3'b101:  return {16'd0, lane[15:0]};
      default: return rdata;
    endcase
  endfunction

  // p0: address phase -- arbitration, fault detection, acceptance
  always_comb begin
    vld_p0      = rst_n && (bus.i_req_valid || bus.d_req_valid);
    sel_d_p0    = bus.d_req_valid && (!bus.i_req_valid || DATA_PRIO || rr_data_first);
    sel_addr_p0 = sel_d_p0 ? bus.d_req_addr : bus.i_req_addr;
    fault_p0    = sel_d_p0 ? data_misaligned(bus.d_req_size, bus.d_req_addr[1:0])
                           : (bus.i_req_addr[1:0] != 2'b00);
    // Both error cycles cancel the pending address phase; it stays pending for re-arbitration.
    err_hold    = (dp_state_p1 == DP_BUSY && !dp_fault_p1 && bus.HRESP) || dp_state_p1 == DP_ERR;
    accept_p0   = vld_p0 && !err_hold && bus.HREADY;
  end

  assign bus.i_req_ready = accept_p0 && !sel_d_p0;
  assign bus.d_req_ready = accept_p0 && sel_d_p0;
  assign bus.HTRANS = (vld_p0 && !err_hold && !fault_p0) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR  = vld_p0 ? sel_addr_p0 : '0;
  assign bus.HWRITE = vld_p0 && sel_d_p0 && bus.d_req_write;
  assign bus.HSIZE  = !vld_p0 ? 3'b000 : (sel_d_p0 ? {1'b0, bus.d_req_size[1:0]} : 3'b010);
  assign bus.HPROT  = !vld_p0 ? 4'b0000 : (sel_d_p0 ? 4'b0011 : 4'b0010);
  assign bus.HBURST = 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_state_p1   <= DP_IDLE;
      rr_data_first <= 1'b1;
    end else if (accept_p0) begin
      dp_state_p1   <= DP_BUSY;
      rr_data_first <= !rr_data_first;
    end else if (dp_state_p1 == DP_BUSY && !dp_fault_p1 && bus.HRESP && !bus.HREADY) begin
      dp_state_p1   <= DP_ERR;
    end else if (dp_state_p1 != DP_IDLE && bus.HREADY) begin
      dp_state_p1   <= DP_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      dp_owner_d_p1 <= sel_d_p0;
      dp_write_p1   <= sel_d_p0 && bus.d_req_write;
      dp_fault_p1   <= fault_p0;
      dp_size_p1    <= sel_d_p0 ? bus.d_req_size : 3'b010;
      dp_addr_p1    <= sel_addr_p0[1:0];
      dp_wdata_p1   <= bus.d_req_wdata;
    end
  end

  // p1: data phase -- write lanes, response steering, load extraction
  assign vld_p1      = dp_state_p1 != DP_IDLE && bus.HREADY;
  assign rsp_err_p1  = dp_fault_p1 || bus.HRESP || dp_state_p1 == DP_ERR;
  assign rsp_data_p1 = rsp_err_p1    ? '0 :
                       dp_owner_d_p1 ? load_extract(bus.HRDATA, dp_size_p1, dp_addr_p1)
                                     : bus.HRDATA;

  assign bus.HWDATA = (dp_state_p1 != DP_IDLE && dp_write_p1) ?
                      store_lanes(dp_wdata_p1, dp_size_p1) : '0;

  assign bus.i_rsp_valid = vld_p1 && !dp_owner_d_p1;
  assign bus.i_rsp_err   = bus.i_rsp_valid && rsp_err_p1;
  assign bus.i_rsp_rdata = bus.i_rsp_valid ? rsp_data_p1 : '0;
  assign bus.d_rsp_valid = vld_p1 && dp_owner_d_p1;
  assign bus.d_rsp_err   = bus.d_rsp_valid && rsp_err_p1;
  assign bus.d_rsp_rdata = bus.d_rsp_valid ? rsp_data_p1 : '0;
endmodule

// File: tb/tb_rv32_ahb_lite_master_pipe.sv
// Directed bench for rv32_ahb_lite_master_pipe: single-transfer vector table plus
// hand-written sequences for pipelining, arbitration, wait states, errors and reset.
module tb_rv32_ahb_lite_master_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rv32_ahb_lite_master_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  rv32_ahb_lite_master_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();

  rv32_ahb_lite_master_pipe #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  rv32_ahb_lite_master_pipe #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr));

  typedef struct {
    string       name;
    logic        is_d;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic [1:0]  e_htrans;
    logic [2:0]  e_hsize;
    logic [3:0]  e_hprot;
    logic [31:0] e_hwdata;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req_valid = 1'b0; bus.i_req_addr  = '0;
    bus.d_req_valid = 1'b0; bus.d_req_addr  = '0;
    bus.d_req_write = 1'b0; bus.d_req_size  = 3'b010; bus.d_req_wdata = '0;
    bus.HRDATA      = '0;   bus.HREADY      = 1'b1;   bus.HRESP       = 1'b0;
  endtask

  task automatic idle_rr();
    bus_rr.i_req_valid = 1'b0; bus_rr.i_req_addr  = '0;
    bus_rr.d_req_valid = 1'b0; bus_rr.d_req_addr  = '0;
    bus_rr.d_req_write = 1'b0; bus_rr.d_req_size  = 3'b010; bus_rr.d_req_wdata = '0;
    bus_rr.HRDATA      = '0;   bus_rr.HREADY      = 1'b1;   bus_rr.HRESP       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"fetch_0x40", 1'b0, 32'h40,  1'b0, 3'b010, 32'h0,        32'h00112233,
                 2'b10, 3'b010, 4'b0010, 32'h0,        1'b0, 32'h00112233};
    vecs[1]  = '{"sb_0x203",   1'b1, 32'h203, 1'b1, 3'b000, 32'h000000A5, 32'h0,
                 2'b10, 3'b000, 4'b0011, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[2]  = '{"lb_0x203",   1'b1, 32'h203, 1'b0, 3'b000, 32'h0,        32'h80123456,
                 2'b10, 3'b000, 4'b0011, 32'h0,        1'b0, 32'hFFFFFF80};
    vecs[3]  = '{"lbu_0x203",  1'b1, 32'h203, 1'b0, 3'b100, 32'h0,        32'h80123456,
                 2'b10, 3'b000, 4'b0011, 32'h0,        1'b0, 32'h00000080};
    vecs[4]  = '{"lhu_0x202",  1'b1, 32'h202, 1'b0, 3'b101, 32'h0,        32'h80011234,
                 2'b10, 3'b001, 4'b0011, 32'h0,        1'b0, 32'h00008001};
    vecs[5]  = '{"lh_0x202",   1'b1, 32'h202, 1'b0, 3'b001, 32'h0,        32'h80011234,
                 2'b10, 3'b001, 4'b0011, 32'h0,        1'b0, 32'hFFFF8001};
    vecs[6]  = '{"lw_0x200",   1'b1, 32'h200, 1'b0, 3'b010, 32'h0,        32'hDEADBEEF,
                 2'b10, 3'b010, 4'b0011, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[7]  = '{"sh_0x102",   1'b1, 32'h102, 1'b1, 3'b001, 32'h1234BEEF, 32'h0,
                 2'b10, 3'b001, 4'b0011, 32'hBEEFBEEF, 1'b0, 32'h0};
    vecs[8]  = '{"sw_0x104",   1'b1, 32'h104, 1'b1, 3'b010, 32'hCAFEF00D, 32'h0,
                 2'b10, 3'b010, 4'b0011, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[9]  = '{"lw_mis_202", 1'b1, 32'h202, 1'b0, 3'b010, 32'h0,        32'h11111111,
                 2'b00, 3'b010, 4'b0011, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{"lh_mis_201", 1'b1, 32'h201, 1'b0, 3'b001, 32'h0,        32'h22222222,
                 2'b00, 3'b001, 4'b0011, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{"if_mis_42",  1'b0, 32'h42,  1'b0, 3'b010, 32'h0,        32'h33333333,
                 2'b00, 3'b010, 4'b0010, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{"lb_0x201",   1'b1, 32'h201, 1'b0, 3'b000, 32'h0,        32'h00007F00,
                 2'b10, 3'b000, 4'b0011, 32'h0,        1'b0, 32'h0000007F};

    // Reset state, with both requesters asserting valid
    rst_n = 1'b0;
    idle_inputs();
    idle_rr();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h10;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h20;
    tick(); tick();
    chk("rst i_req_ready", 32'(bus.i_req_ready), 32'h0);
    chk("rst d_req_ready", 32'(bus.d_req_ready), 32'h0);
    chk("rst htrans",      32'(bus.HTRANS),      32'h0);
    chk("rst haddr",       bus.HADDR,            32'h0);
    chk("rst hwdata",      bus.HWDATA,           32'h0);
    chk("rst d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);
    chk("rst i_rsp_valid", 32'(bus.i_rsp_valid), 32'h0);
    rst_n = 1'b1;
    idle_inputs();
    tick();

    // Single transfers: address phase then data phase
    for (int k = 0; k < NV; k++) begin
      idle_inputs();
      if (vecs[k].is_d) begin
        bus.d_req_valid = 1'b1;          bus.d_req_addr  = vecs[k].addr;
        bus.d_req_write = vecs[k].wr;    bus.d_req_size  = vecs[k].size;
        bus.d_req_wdata = vecs[k].wdata;
      end else begin
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = vecs[k].addr;
      end
      settle();
      chk({vecs[k].name, " htrans"}, 32'(bus.HTRANS), 32'(vecs[k].e_htrans));
      chk({vecs[k].name, " haddr"},  bus.HADDR,       vecs[k].addr);
      chk({vecs[k].name, " hsize"},  32'(bus.HSIZE),  32'(vecs[k].e_hsize));
      chk({vecs[k].name, " hprot"},  32'(bus.HPROT),  32'(vecs[k].e_hprot));
      chk({vecs[k].name, " hwrite"}, 32'(bus.HWRITE), 32'(vecs[k].wr));
      chk({vecs[k].name, " ready"},
          32'(vecs[k].is_d ? bus.d_req_ready : bus.i_req_ready), 32'h1);
      tick();
      idle_inputs();
      bus.HRDATA = vecs[k].hrdata;
      settle();
      chk({vecs[k].name, " hwdata"}, bus.HWDATA, vecs[k].e_hwdata);
      if (vecs[k].is_d) begin
        chk({vecs[k].name, " d_rsp_valid"}, 32'(bus.d_rsp_valid), 32'h1);
        chk({vecs[k].name, " i_rsp_valid"}, 32'(bus.i_rsp_valid), 32'h0);
        chk({vecs[k].name, " d_rsp_err"},   32'(bus.d_rsp_err),   32'(vecs[k].e_err));
        chk({vecs[k].name, " d_rsp_rdata"}, bus.d_rsp_rdata,      vecs[k].e_rdata);
      end else begin
        chk({vecs[k].name, " i_rsp_valid"}, 32'(bus.i_rsp_valid), 32'h1);
        chk({vecs[k].name, " d_rsp_valid"}, 32'(bus.d_rsp_valid), 32'h0);
        chk({vecs[k].name, " i_rsp_err"},   32'(bus.i_rsp_err),   32'(vecs[k].e_err));
        chk({vecs[k].name, " i_rsp_rdata"}, bus.i_rsp_rdata,      vecs[k].e_rdata);
      end
      tick();
    end

    // Back-to-back fetches 0x0, 0x4, 0x8 with zero wait states
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      bus.i_req_valid = (c < 3);
      bus.i_req_addr  = 32'(c * 4);
      bus.HRDATA      = 32'h1000 + 32'((c - 1) * 4);
      settle();
      if (c < 3) begin
        chk($sformatf("b2b%0d htrans", c), 32'(bus.HTRANS), 32'h2);
        chk($sformatf("b2b%0d ready", c),  32'(bus.i_req_ready), 32'h1);
      end
      if (c > 0) begin
        chk($sformatf("b2b%0d i_rsp_valid", c), 32'(bus.i_rsp_valid), 32'h1);
        chk($sformatf("b2b%0d i_rsp_rdata", c), bus.i_rsp_rdata, 32'h1000 + 32'((c - 1) * 4));
      end
      tick();
    end

    // Fixed data priority: load wins, then the fetch
    idle_inputs();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h100;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h200;
    settle();
    chk("prio first haddr", bus.HADDR,            32'h200);
    chk("prio first hprot", 32'(bus.HPROT),       32'h3);
    chk("prio i_ready low", 32'(bus.i_req_ready), 32'h0);
    tick();
    bus.d_req_valid = 1'b0;
    bus.HRDATA      = 32'h55;
    settle();
    chk("prio second haddr", bus.HADDR,            32'h100);
    chk("prio second hprot", 32'(bus.HPROT),       32'h2);
    chk("prio d_rsp_rdata",  bus.d_rsp_rdata,      32'h55);
    chk("prio i_ready",      32'(bus.i_req_ready), 32'h1);
    tick();
    idle_inputs();
    bus.HRDATA = 32'h77;
    settle();
    chk("prio i_rsp_rdata", bus.i_rsp_rdata, 32'h77);
    tick();

    // Round-robin instance: alternates data, fetch, data, fetch
    bus_rr.i_req_valid = 1'b1; bus_rr.i_req_addr = 32'h100;
    bus_rr.d_req_valid = 1'b1; bus_rr.d_req_addr = 32'h200;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("rr%0d hprot", c),   32'(bus_rr.HPROT),       (c % 2 == 0) ? 32'h3 : 32'h2);
      chk($sformatf("rr%0d d_ready", c), 32'(bus_rr.d_req_ready), (c % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr%0d i_ready", c), 32'(bus_rr.i_req_ready), (c % 2 == 0) ? 32'h0 : 32'h1);
      tick();
    end
    idle_rr();
    tick();

    // Wait states: load data phase stretched by 3 cycles with a fetch pending
    idle_inputs();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h300;
    tick();
    bus.d_req_valid = 1'b0;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h400;
    bus.HREADY      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("ws%0d haddr", c),       bus.HADDR,            32'h400);
      chk($sformatf("ws%0d htrans", c),      32'(bus.HTRANS),      32'h2);
      chk($sformatf("ws%0d d_rsp_valid", c), 32'(bus.d_rsp_valid), 32'h0);
      chk($sformatf("ws%0d i_ready", c),     32'(bus.i_req_ready), 32'h0);
      tick();
    end
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hA1B2C3D4;
    settle();
    chk("ws3 d_rsp_valid", 32'(bus.d_rsp_valid), 32'h1);
    chk("ws3 d_rsp_rdata", bus.d_rsp_rdata,      32'hA1B2C3D4);
    chk("ws3 i_ready",     32'(bus.i_req_ready), 32'h1);
    tick();
    idle_inputs();
    bus.HRDATA = 32'h13;
    settle();
    chk("ws fetch i_rsp_valid", 32'(bus.i_rsp_valid), 32'h1);
    chk("ws fetch i_rsp_rdata", bus.i_rsp_rdata,      32'h13);
    tick();

    // Two-cycle error on a store with a fetch pending
    idle_inputs();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h500;
    bus.d_req_write = 1'b1; bus.d_req_wdata = 32'h12345678;
    tick();
    idle_inputs();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h600;
    bus.HRESP = 1'b1; bus.HREADY = 1'b0;
    settle();
    chk("err1 htrans",      32'(bus.HTRANS),      32'h0);
    chk("err1 i_ready",     32'(bus.i_req_ready), 32'h0);
    chk("err1 d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);
    chk("err1 hwdata",      bus.HWDATA,           32'h12345678);
    tick();
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hFFFFFFFF;
    settle();
    chk("err2 htrans",      32'(bus.HTRANS),      32'h0);
    chk("err2 i_ready",     32'(bus.i_req_ready), 32'h0);
    chk("err2 d_rsp_valid", 32'(bus.d_rsp_valid), 32'h1);
    chk("err2 d_rsp_err",   32'(bus.d_rsp_err),   32'h1);
    chk("err2 d_rsp_rdata", bus.d_rsp_rdata,      32'h0);
    tick();
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    settle();
    chk("err3 htrans",      32'(bus.HTRANS),      32'h2);
    chk("err3 haddr",       bus.HADDR,            32'h600);
    chk("err3 i_ready",     32'(bus.i_req_ready), 32'h1);
    chk("err3 d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);
    tick();
    idle_inputs();
    bus.HRDATA = 32'h99;
    settle();
    chk("err4 i_rsp_valid", 32'(bus.i_rsp_valid), 32'h1);
    chk("err4 i_rsp_err",   32'(bus.i_rsp_err),   32'h0);
    tick();

    // Reset asserted during a store data phase
    idle_inputs();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h700;
    bus.d_req_write = 1'b1; bus.d_req_wdata = 32'hFFFF0000;
    tick();
    idle_inputs();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h800;
    settle();
    chk("prerst hwdata", bus.HWDATA, 32'hFFFF0000);
    rst_n = 1'b0;
    settle();
    chk("midrst d_rsp_valid", 32'(bus.d_rsp_valid), 32'h0);
    chk("midrst i_ready",     32'(bus.i_req_ready), 32'h0);
    chk("midrst htrans",      32'(bus.HTRANS),      32'h0);
    chk("midrst haddr",       bus.HADDR,            32'h0);
    chk("midrst hwdata",      bus.HWDATA,           32'h0);
    tick(); tick();
    rst_n = 1'b1;
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("postrst%0d d_rsp_valid", c), 32'(bus.d_rsp_valid), 32'h0);
      chk($sformatf("postrst%0d hwdata", c),      bus.HWDATA,            32'h0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
